// File: rtl/sample_loader_if.sv
// Sample stream in (valid/ready) and sample RAM write port out, bundled as one bus.
interface sample_loader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output s_data, s_valid,
        input  s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/sample_loader.sv
// DFT input stage: streams one frame of samples into the sample RAM, then
// flags data_loaded to the compute FSM until it leaves its load phase.
module sample_loader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [11:0]      sample_num,
    input  logic             load_nCompute,
    sample_loader_if.slave   bus,
    output logic             data_loaded,
    output logic [1:0]       state
);
    // One extra bit so a full 2^ADDR_W frame length is representable.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(1) << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              loaded_q, loaded_d;
    logic              s_ready;
    logic              xfer;

    assign s_ready = ce && (state_q == FILL);
    assign xfer    = bus.s_valid && s_ready;

    // Next-state and registered-output logic for one enabled cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        loaded_d  = loaded_q;
        case (state_q)
            IDLE: begin
                if (load_nCompute) begin
                    len_d   = (sample_num == 12'd0) ? FULL_LEN : CNT_W'(sample_num);
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = bus.s_data;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d  = DONE;
                        loaded_d = 1'b1;
                    end
                end
            end
            DONE: begin
                // Compute FSM leaving its load phase is the acknowledge.
                if (!load_nCompute) begin
                    state_d  = IDLE;
                    loaded_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                loaded_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            loaded_q  <= 1'b0;
        end else if (ce) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            loaded_q  <= loaded_d;
        end
    end

    // The write strobe is held with ce low but masked so the RAM never sees it.
    assign bus.s_ready = s_ready;
    assign bus.wr_en   = wr_en_q && ce;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign data_loaded = loaded_q;
    assign state       = state_q;
endmodule
